// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and widths used by the evict data path.
package vector_cache_pkg;

    localparam int unsigned DATA_WIDTH            = 1024;
    localparam int unsigned ADDR_WIDTH            = 40;
    localparam int unsigned TXN_ID_WIDTH          = 8;
    localparam int unsigned DB_ENTRY_IDX_WIDTH    = 4;
    localparam int unsigned ROB_ENTRY_IDX_WIDTH   = 5;
    localparam int unsigned SIDEBAND_WIDTH        = 8;
    localparam int unsigned DEFAULT_DS_BEAT_WIDTH = 256;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]          data;
        logic [ADDR_WIDTH-1:0]          addr;
        logic [TXN_ID_WIDTH-1:0]        txn_id;
        logic [DB_ENTRY_IDX_WIDTH-1:0]  db_entry_id;
        logic [ROB_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
        logic [SIDEBAND_WIDTH-1:0]      sideband;
    } evict_to_ds_pld_t;

    typedef struct packed {
        logic [TXN_ID_WIDTH-1:0]       txn_id;
        logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
    } ds_wr_track_t;

    typedef enum logic [1:0] {
        DS_WR_IDLE = 2'd0,
        DS_WR_AW   = 2'd1,
        DS_WR_W    = 2'd2
    } ds_wr_state_e;

endpackage

// File: rtl/vec_cache_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push when full and pop when empty are ignored.
module vec_cache_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/vec_cache_evict_ds_writer.sv
// Drains evicted lines to downstream memory as AW + multi-beat W, and releases
// evict-buffer entries in order as write responses return.
module vec_cache_evict_ds_writer
    import vector_cache_pkg::*;
#(
    parameter int unsigned IN_FIFO_DEPTH   = 4,
    parameter int unsigned DS_BEAT_WIDTH   = DEFAULT_DS_BEAT_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          evict_to_ds_vld,
    input  evict_to_ds_pld_t              evict_to_ds_pld,
    output logic                          evict_to_ds_rdy,
    output logic                          ds_aw_vld,
    output logic [ADDR_WIDTH-1:0]         ds_aw_addr,
    output logic [TXN_ID_WIDTH-1:0]       ds_aw_id,
    input  logic                          ds_aw_rdy,
    output logic                          ds_w_vld,
    output logic [DS_BEAT_WIDTH-1:0]      ds_w_data,
    output logic                          ds_w_last,
    input  logic                          ds_w_rdy,
    input  logic                          ds_b_vld,
    input  logic [TXN_ID_WIDTH-1:0]       ds_b_id,
    output logic                          ds_b_rdy,
    output logic                          evdb_release_vld,
    output logic [DB_ENTRY_IDX_WIDTH-1:0] evdb_release_idx,
    output logic                          err_overflow,
    output logic                          err_resp
);

    localparam int unsigned BEATS     = DATA_WIDTH / DS_BEAT_WIDTH;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned IN_CNT_W  = $clog2(IN_FIFO_DEPTH) + 1;
    localparam int unsigned TRK_W     = $bits(ds_wr_track_t);
    localparam int unsigned PLD_W     = $bits(evict_to_ds_pld_t);

    ds_wr_state_e                state_q, state_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic [OUT_W-1:0]            outstanding_q, outstanding_d;
    logic                        release_vld_q, release_vld_d;
    logic [DB_ENTRY_IDX_WIDTH-1:0] release_idx_q, release_idx_d;
    logic                        err_overflow_q, err_overflow_d;
    logic                        err_resp_q, err_resp_d;

    evict_to_ds_pld_t            in_head;
    logic                        in_push, in_pop, in_full, in_empty;
    logic [IN_CNT_W-1:0]         in_count;
    logic [BEATS-1:0][DS_BEAT_WIDTH-1:0] head_beats;

    ds_wr_track_t                trk_wdata, trk_head;
    logic                        trk_push, trk_pop, trk_full, trk_empty;
    logic [OUT_W-1:0]            trk_count;
    logic                        b_err;
    logic                        sink_unused;

    assign evict_to_ds_rdy = !in_full;
    assign in_push         = evict_to_ds_vld && evict_to_ds_rdy;

    vec_cache_sync_fifo #(
        .WIDTH (PLD_W),
        .DEPTH (IN_FIFO_DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_push),
        .data_i  (evict_to_ds_pld),
        .pop_i   (in_pop),
        .data_o  (in_head),
        .full_o  (in_full),
        .empty_o (in_empty),
        .count_o (in_count)
    );

    assign trk_wdata.txn_id      = in_head.txn_id;
    assign trk_wdata.db_entry_id = in_head.db_entry_id;

    vec_cache_sync_fifo #(
        .WIDTH (TRK_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_trk_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (trk_push),
        .data_i  (trk_wdata),
        .pop_i   (trk_pop),
        .data_o  (trk_head),
        .full_o  (trk_full),
        .empty_o (trk_empty),
        .count_o (trk_count)
    );

    // Occupancy and optional payload fields are carried but not needed here.
    assign sink_unused = ^{in_count, trk_full, trk_count, in_head.rob_entry_id, in_head.sideband};

    assign head_beats = in_head.data;

    assign ds_aw_vld  = (state_q == DS_WR_AW);
    assign ds_aw_addr = in_head.addr;
    assign ds_aw_id   = in_head.txn_id;
    assign ds_w_vld   = (state_q == DS_WR_W);
    assign ds_w_data  = head_beats[beat_q];
    assign ds_w_last  = (state_q == DS_WR_W) && (beat_q == BEAT_W'(BEATS - 1));
    assign ds_b_rdy   = 1'b1;

    assign evdb_release_vld = release_vld_q;
    assign evdb_release_idx = release_idx_q;
    assign err_overflow     = err_overflow_q;
    assign err_resp         = err_resp_q;

    // Line-issue FSM: IDLE gates on outstanding budget, AW then BEATS data beats.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        in_pop   = 1'b0;
        trk_push = 1'b0;
        unique case (state_q)
            DS_WR_IDLE: begin
                if (!in_empty && (outstanding_q < OUT_W'(MAX_OUTSTANDING))) begin
                    state_d = DS_WR_AW;
                end
            end
            DS_WR_AW: begin
                if (ds_aw_rdy) begin
                    trk_push = 1'b1;
                    beat_d   = '0;
                    state_d  = DS_WR_W;
                end
            end
            DS_WR_W: begin
                if (ds_w_rdy) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        in_pop  = 1'b1;
                        beat_d  = '0;
                        state_d = DS_WR_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = DS_WR_IDLE;
        endcase
    end

    // Response side: in-order match against the tracker head.
    always_comb begin
        trk_pop        = ds_b_vld && !trk_empty;
        b_err          = ds_b_vld && (trk_empty || (ds_b_id != trk_head.txn_id));
        release_vld_d  = trk_pop;
        release_idx_d  = trk_pop ? trk_head.db_entry_id : release_idx_q;
        err_resp_d     = err_resp_q || b_err;
        err_overflow_d = err_overflow_q || (evict_to_ds_vld && !evict_to_ds_rdy);
        outstanding_d  = outstanding_q;
        unique case ({trk_push, trk_pop})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= DS_WR_IDLE;
            beat_q         <= '0;
            outstanding_q  <= '0;
            release_vld_q  <= 1'b0;
            release_idx_q  <= '0;
            err_overflow_q <= 1'b0;
            err_resp_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            outstanding_q  <= outstanding_d;
            release_vld_q  <= release_vld_d;
            release_idx_q  <= release_idx_d;
            err_overflow_q <= err_overflow_d;
            err_resp_q     <= err_resp_d;
        end
    end

endmodule

// File: tb/tb_vec_cache_evict_ds_writer.sv
// Directed bench for vec_cache_evict_ds_writer with a queue-based scoreboard.
module tb_vec_cache_evict_ds_writer;
    import vector_cache_pkg::*;

    localparam int unsigned BW    = 256;
    localparam int unsigned BEATS = DATA_WIDTH / BW;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          evict_to_ds_vld = 1'b0;
    evict_to_ds_pld_t              evict_to_ds_pld = '0;
    logic                          evict_to_ds_rdy;
    logic                          ds_aw_vld;
    logic [ADDR_WIDTH-1:0]         ds_aw_addr;
    logic [TXN_ID_WIDTH-1:0]       ds_aw_id;
    logic                          ds_aw_rdy = 1'b1;
    logic                          ds_w_vld;
    logic [BW-1:0]                 ds_w_data;
    logic                          ds_w_last;
    logic                          ds_w_rdy = 1'b1;
    logic                          ds_b_vld = 1'b0;
    logic [TXN_ID_WIDTH-1:0]       ds_b_id = '0;
    logic                          ds_b_rdy;
    logic                          evdb_release_vld;
    logic [DB_ENTRY_IDX_WIDTH-1:0] evdb_release_idx;
    logic                          err_overflow;
    logic                          err_resp;

    always #5 clk = ~clk;

    vec_cache_evict_ds_writer #(
        .IN_FIFO_DEPTH   (4),
        .DS_BEAT_WIDTH   (BW),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .evict_to_ds_vld  (evict_to_ds_vld),
        .evict_to_ds_pld  (evict_to_ds_pld),
        .evict_to_ds_rdy  (evict_to_ds_rdy),
        .ds_aw_vld        (ds_aw_vld),
        .ds_aw_addr       (ds_aw_addr),
        .ds_aw_id         (ds_aw_id),
        .ds_aw_rdy        (ds_aw_rdy),
        .ds_w_vld         (ds_w_vld),
        .ds_w_data        (ds_w_data),
        .ds_w_last        (ds_w_last),
        .ds_w_rdy         (ds_w_rdy),
        .ds_b_vld         (ds_b_vld),
        .ds_b_id          (ds_b_id),
        .ds_b_rdy         (ds_b_rdy),
        .evdb_release_vld (evdb_release_vld),
        .evdb_release_idx (evdb_release_idx),
        .err_overflow     (err_overflow),
        .err_resp         (err_resp)
    );

    int checks   = 0;
    int failures = 0;
    int aw_count = 0;
    bit rand_w   = 1'b0;

    logic [ADDR_WIDTH+TXN_ID_WIDTH-1:0] exp_aw [$];
    logic [BW:0]                        exp_w [$];
    logic [DB_ENTRY_IDX_WIDTH-1:0]      exp_rel [$];
    evict_to_ds_pld_t                   line_q [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_avail(input string tag, input int size);
        checks++;
        assert (size > 0) else begin
            failures++;
            $error("FAIL %s: observed unexpected output, expected none pending", tag);
        end
    endtask

    // Output monitor: pops scoreboard entries on every handshake / release.
    logic                               stall_aw = 1'b0;
    logic                               stall_w  = 1'b0;
    logic [ADDR_WIDTH+TXN_ID_WIDTH-1:0] prev_aw;
    logic [BW:0]                        prev_w;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_aw = 1'b0;
            stall_w  = 1'b0;
        end else begin
            if (stall_aw) chk("aw_stable", 256'({ds_aw_vld, ds_aw_addr, ds_aw_id}), 256'({1'b1, prev_aw}));
            if (stall_w)  chk("w_stable", 256'({ds_w_vld, ds_w_last}), 256'({1'b1, prev_w[BW]}));
            if (stall_w)  chk("w_data_stable", ds_w_data, prev_w[BW-1:0]);
            if (ds_aw_vld && ds_aw_rdy) begin
                aw_count++;
                chk_avail("aw_unexpected", exp_aw.size());
                if (exp_aw.size() > 0) chk("aw_addr_id", 256'({ds_aw_addr, ds_aw_id}), 256'(exp_aw.pop_front()));
            end
            if (ds_w_vld && ds_w_rdy) begin
                chk_avail("w_unexpected", exp_w.size());
                if (exp_w.size() > 0) begin
                    logic [BW:0] e;
                    e = exp_w.pop_front();
                    chk("w_data", ds_w_data, e[BW-1:0]);
                    chk("w_last", 256'(ds_w_last), 256'(e[BW]));
                end
            end
            if (evdb_release_vld) begin
                chk_avail("rel_unexpected", exp_rel.size());
                if (exp_rel.size() > 0) chk("rel_idx", 256'(evdb_release_idx), 256'(exp_rel.pop_front()));
            end
            stall_aw = ds_aw_vld && !ds_aw_rdy;
            stall_w  = ds_w_vld && !ds_w_rdy;
            prev_aw  = {ds_aw_addr, ds_aw_id};
            prev_w   = {ds_w_last, ds_w_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic evict_to_ds_pld_t mk(input int k);
        evict_to_ds_pld_t p;
        p = '0;
        for (int i = 0; i < int'(BEATS); i++) begin
            p.data[i*BW +: BW] = {8{32'(((i + 10) << 28) | (k << 8) | i)}};
        end
        p.addr         = ADDR_WIDTH'(64'h1000 + 64'(k) * 64);
        p.txn_id       = TXN_ID_WIDTH'(k + 16);
        p.db_entry_id  = DB_ENTRY_IDX_WIDTH'(k);
        p.rob_entry_id = ROB_ENTRY_IDX_WIDTH'(k);
        p.sideband     = SIDEBAND_WIDTH'(k);
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_w) ds_w_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_line(input evict_to_ds_pld_t p);
        exp_aw.push_back({p.addr, p.txn_id});
        for (int i = 0; i < int'(BEATS); i++) begin
            exp_w.push_back({(i == int'(BEATS) - 1), p.data[i*BW +: BW]});
        end
        line_q.push_back(p);
    endtask

    task automatic send(input evict_to_ds_pld_t p, output bit acc);
        evict_to_ds_pld = p;
        evict_to_ds_vld = 1'b1;
        acc = evict_to_ds_rdy;
        if (acc) expect_line(p);
        step();
        evict_to_ds_vld = 1'b0;
    endtask

    task automatic send_wait(input evict_to_ds_pld_t p);
        int n;
        bit acc;
        n = 0;
        while (!evict_to_ds_rdy && n < 200) begin
            step();
            n++;
        end
        chk("send_rdy_wait", 256'(evict_to_ds_rdy), 256'(1));
        send(p, acc);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_w.size() != 0 || exp_aw.size() != 0) && n < 600) begin
            step();
            n++;
        end
        chk(tag, 256'(exp_w.size() + exp_aw.size()), 256'(0));
    endtask

    task automatic send_b(input logic [TXN_ID_WIDTH-1:0] id, input bit rel, input logic [DB_ENTRY_IDX_WIDTH-1:0] idx);
        ds_b_vld = 1'b1;
        ds_b_id  = id;
        if (rel) exp_rel.push_back(idx);
        step();
        ds_b_vld = 1'b0;
    endtask

    task automatic respond_next();
        evict_to_ds_pld_t p;
        p = line_q.pop_front();
        send_b(p.txn_id, 1'b1, p.db_entry_id);
    endtask

    initial begin
        evict_to_ds_pld_t p;
        bit acc;
        int nacc;
        int base;
        int n;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_aw_vld", 256'(ds_aw_vld), 256'(0));
        chk("rst_w_vld", 256'(ds_w_vld), 256'(0));
        chk("rst_w_last", 256'(ds_w_last), 256'(0));
        chk("rst_in_rdy", 256'(evict_to_ds_rdy), 256'(1));
        chk("rst_b_rdy", 256'(ds_b_rdy), 256'(1));
        chk("rst_rel_vld", 256'(evdb_release_vld), 256'(0));
        chk("rst_err_ovf", 256'(err_overflow), 256'(0));
        chk("rst_err_resp", 256'(err_resp), 256'(0));

        // Single line: AW at +2, four ordered beats, release one cycle after B.
        p = mk(0);
        send(p, acc);
        chk("t1_accept", 256'(acc), 256'(1));
        chk("t1_aw_n1", 256'(ds_aw_vld), 256'(0));
        step();
        chk("t1_aw_n2", 256'(ds_aw_vld), 256'(1));
        chk("t1_aw_addr", 256'(ds_aw_addr), 256'(p.addr));
        chk("t1_aw_id", 256'(ds_aw_id), 256'(p.txn_id));
        step();
        for (int i = 0; i < int'(BEATS); i++) begin
            chk("t1_w_vld", 256'(ds_w_vld), 256'(1));
            chk("t1_w_beat", ds_w_data, p.data[i*BW +: BW]);
            chk("t1_w_last", 256'(ds_w_last), 256'(i == int'(BEATS) - 1));
            step();
        end
        chk("t1_w_done", 256'(ds_w_vld), 256'(0));
        respond_next();
        chk("t1_rel_vld", 256'(evdb_release_vld), 256'(1));
        chk("t1_rel_idx", 256'(evdb_release_idx), 256'(p.db_entry_id));
        step();
        chk("t1_rel_pulse", 256'(evdb_release_vld), 256'(0));

        // Queue fills behind a stalled AW; fifth line overflows.
        ds_aw_rdy = 1'b0;
        nacc = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) chk("t2_rdy_full", 256'(evict_to_ds_rdy), 256'(0));
            send(mk(k), acc);
            nacc += int'(acc);
            if (k == 4) chk("t2_ovf_clear", 256'(err_overflow), 256'(0));
        end
        chk("t2_accepted", 256'(nacc), 256'(4));
        chk("t2_err_ovf", 256'(err_overflow), 256'(1));
        step();
        ds_aw_rdy = 1'b1;
        drain("t2_drain");
        for (int k = 0; k < 4; k++) respond_next();
        step();
        step();
        chk("t2_rel_done", 256'(exp_rel.size()), 256'(0));

        // Outstanding limit: 9 lines without responses, only 8 AWs.
        base = aw_count;
        for (int k = 6; k <= 14; k++) send_wait(mk(k));
        n = 0;
        while (exp_w.size() > BEATS && n < 400) begin
            step();
            n++;
        end
        repeat (10) step();
        chk("t3_aw_count", 256'(aw_count - base), 256'(8));
        chk("t3_aw_held", 256'(ds_aw_vld), 256'(0));
        respond_next();
        chk("t3_aw_m1", 256'(ds_aw_vld), 256'(0));
        step();
        chk("t3_aw_m2", 256'(ds_aw_vld), 256'(1));
        drain("t3_drain");
        for (int k = 0; k < 8; k++) respond_next();
        step();
        step();
        chk("t3_rel_done", 256'(exp_rel.size()), 256'(0));

        // Random W backpressure.
        rand_w = 1'b1;
        for (int k = 15; k <= 17; k++) send_wait(mk(k));
        drain("t4_drain");
        rand_w = 1'b0;
        ds_w_rdy = 1'b1;
        for (int k = 0; k < 3; k++) respond_next();
        step();
        step();
        chk("t4_rel_done", 256'(exp_rel.size()), 256'(0));

        // Wrong response id still releases the head entry.
        send_wait(mk(18));
        drain("t5_drain");
        chk("t5_resp_clear", 256'(err_resp), 256'(0));
        p = line_q.pop_front();
        send_b(p.txn_id ^ TXN_ID_WIDTH'(8'hFF), 1'b1, p.db_entry_id);
        chk("t5_err_resp", 256'(err_resp), 256'(1));
        chk("t5_rel_vld", 256'(evdb_release_vld), 256'(1));
        chk("t5_rel_idx", 256'(evdb_release_idx), 256'(p.db_entry_id));
        step();

        // Reset in the middle of beat 2; the partial line is lost.
        p = mk(19);
        send_wait(p);
        n = 0;
        while (!(ds_w_vld && ds_w_data === p.data[2*BW +: BW]) && n < 50) begin
            step();
            n++;
        end
        chk("t6_at_beat2", ds_w_data, p.data[2*BW +: BW]);
        rst_n = 1'b0;
        exp_aw.delete();
        exp_w.delete();
        exp_rel.delete();
        line_q.delete();
        step();
        chk("t6_aw_vld", 256'(ds_aw_vld), 256'(0));
        chk("t6_w_vld", 256'(ds_w_vld), 256'(0));
        chk("t6_w_last", 256'(ds_w_last), 256'(0));
        chk("t6_rel_vld", 256'(evdb_release_vld), 256'(0));
        chk("t6_err_ovf", 256'(err_overflow), 256'(0));
        chk("t6_err_resp", 256'(err_resp), 256'(0));
        chk("t6_b_rdy", 256'(ds_b_rdy), 256'(1));
        step();
        rst_n = 1'b1;
        step();
        p = mk(20);
        send(p, acc);
        chk("t6_accept", 256'(acc), 256'(1));
        drain("t6_drain");
        respond_next();
        chk("t6_rel_vld_after", 256'(evdb_release_vld), 256'(1));
        step();

        // Response with nothing outstanding: error, no release.
        chk("t7_resp_clear", 256'(err_resp), 256'(0));
        send_b(TXN_ID_WIDTH'(8'h55), 1'b0, '0);
        chk("t7_err_resp", 256'(err_resp), 256'(1));
        chk("t7_no_rel", 256'(evdb_release_vld), 256'(0));
        step();

        chk("final_empty", 256'(exp_aw.size() + exp_w.size() + exp_rel.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
